// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// The arbiter takes the slave modport; requesters and the RAM take the master side.
interface ram_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [15:0] a_wdata;
  logic [15:0] a_rdata;
  logic        a_ack;

  logic        b_req;
  logic        b_we;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata;
  logic        b_ack;

  logic [15:0] ram_address;
  logic [15:0] ram_data_out;
  logic        ram_rw;
  logic [15:0] ram_data_in;

  logic        busy;
  logic        grant_id;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_data_in,
    output a_rdata, a_ack, b_rdata, b_ack,
    output ram_address, ram_data_out, ram_rw,
    output busy, grant_id
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_data_in,
    input  a_rdata, a_ack, b_rdata, b_ack,
    input  ram_address, ram_data_out, ram_rw,
    input  busy, grant_id
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one fixed-latency 16-bit RAM between port A (CPU) and port B.
// Ties alternate via the last-grant register, which resets to B so A wins the first tie.
module ram_arbiter #(
  parameter int RAM_LATENCY = 1
) (
  input  logic         clock,
  input  logic         resetn,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] LOAD = 2'(RAM_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic       last;
  logic       is_write;
  logic [1:0] count;
  logic       grant_valid;
  logic       grant_sel;
  logic       sel_we;
  logic       finish;

  // A write always completes one cycle after grant; a read once the latency count runs out.
  assign finish   = ((state == ACCESS) || (state == WAIT)) && (is_write || (count == 2'd0));
  assign sel_we   = grant_sel ? bus.b_we : bus.a_we;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant_sel   = last;
    case (state)
      IDLE: begin
        if (bus.a_req && bus.b_req) begin
          grant_valid = 1'b1;
          grant_sel   = ~last;
        end else if (bus.a_req) begin
          grant_valid = 1'b1;
          grant_sel   = 1'b0;
        end else if (bus.b_req) begin
          grant_valid = 1'b1;
          grant_sel   = 1'b1;
        end
        if (grant_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS, WAIT: state_next = finish ? DONE : WAIT;
      DONE:         state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.a_rdata      <= 16'h0000;
      bus.b_rdata      <= 16'h0000;
      bus.a_ack        <= 1'b0;
      bus.b_ack        <= 1'b0;
      bus.ram_address  <= 16'h0000;
      bus.ram_data_out <= 16'h0000;
      bus.ram_rw       <= 1'b0;
      bus.grant_id     <= 1'b0;
      last             <= 1'b1;
      is_write         <= 1'b0;
      count            <= 2'd0;
    end else begin
      bus.a_ack  <= 1'b0;
      bus.b_ack  <= 1'b0;
      bus.ram_rw <= 1'b0;
      if (grant_valid) begin
        bus.ram_address <= grant_sel ? bus.b_addr : bus.a_addr;
        if (sel_we) begin
          bus.ram_data_out <= grant_sel ? bus.b_wdata : bus.a_wdata;
        end
        bus.ram_rw   <= sel_we;
        is_write     <= sel_we;
        bus.grant_id <= grant_sel;
        last         <= grant_sel;
        count        <= sel_we ? 2'd0 : LOAD;
      end else if (finish) begin
        // Only the owner's ack/rdata move; the other port is left untouched.
        if (bus.grant_id) begin
          bus.b_ack <= 1'b1;
          if (!is_write) begin
            bus.b_rdata <= bus.ram_data_in;
          end
        end else begin
          bus.a_ack <= 1'b1;
          if (!is_write) begin
            bus.a_rdata <= bus.ram_data_in;
          end
        end
      end else if ((state == ACCESS) || (state == WAIT)) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: two instances (latency 1 and 3) with a behavioural RAM each.
// Stimulus pushes expected acks (data, cycle, owner) into per-port queues; a negedge monitor pops them.
module tb_ram_arbiter;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    int          cycle;
    string       name;
  } exp_t;

  logic  clock = 1'b0;
  logic  rst1;
  logic  rst3;
  int    cycle  = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb [4][$];

  logic [15:0] mem1 [logic [15:0]];
  logic [15:0] mem3 [logic [15:0]];

  logic [3:0]  mon_ack;
  logic [3:0]  mon_gid;
  logic [15:0] mon_rd [4];

  ram_arbiter_if bus1 ();
  ram_arbiter_if bus3 ();

  ram_arbiter #(.RAM_LATENCY(1)) dut1 (.clock(clock), .resetn(rst1), .bus(bus1));
  ram_arbiter #(.RAM_LATENCY(3)) dut3 (.clock(clock), .resetn(rst3), .bus(bus3));

  always #5 clock = ~clock;

  always @(posedge clock) cycle = cycle + 1;

  // Unwritten RAM locations return a fixed pattern derived from the address.
  function automatic logic [15:0] seed_value(input logic [15:0] a);
    if (a == 16'hFFFF) return 16'hBEEF;
    return a ^ 16'h5A00;
  endfunction

  always @(posedge clock) begin
    if (bus1.ram_rw) mem1[bus1.ram_address] = bus1.ram_data_out;
    if (bus3.ram_rw) mem3[bus3.ram_address] = bus3.ram_data_out;
  end

  always @(negedge clock) begin
    bus1.ram_data_in = mem1.exists(bus1.ram_address) ? mem1[bus1.ram_address] : seed_value(bus1.ram_address);
    bus3.ram_data_in = mem3.exists(bus3.ram_address) ? mem3[bus3.ram_address] : seed_value(bus3.ram_address);
  end

  task automatic drive(input int dut, input bit port, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (dut == 1 && !port) begin
      bus1.a_req = req; bus1.a_we = we; bus1.a_addr = addr; bus1.a_wdata = wdata;
    end else if (dut == 1) begin
      bus1.b_req = req; bus1.b_we = we; bus1.b_addr = addr; bus1.b_wdata = wdata;
    end else if (!port) begin
      bus3.a_req = req; bus3.a_we = we; bus3.a_addr = addr; bus3.a_wdata = wdata;
    end else begin
      bus3.b_req = req; bus3.b_we = we; bus3.b_addr = addr; bus3.b_wdata = wdata;
    end
  endtask

  function automatic logic get_ack(input int dut, input bit port);
    if (dut == 1) return port ? bus1.b_ack : bus1.a_ack;
    return port ? bus3.b_ack : bus3.a_ack;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_zero(input int dut, input string name);
    logic [68:0] o;
    if (dut == 1)
      o = {bus1.a_rdata, bus1.b_rdata, bus1.a_ack, bus1.b_ack, bus1.ram_address,
           bus1.ram_data_out, bus1.ram_rw, bus1.busy, bus1.grant_id};
    else
      o = {bus3.a_rdata, bus3.b_rdata, bus3.a_ack, bus3.b_ack, bus3.ram_address,
           bus3.ram_data_out, bus3.ram_rw, bus3.busy, bus3.grant_id};
    checks++;
    if (o !== 69'd0) begin
      errors++;
      $display("[TB] FAIL %s: outputs=%h required=0", name, o);
    end
  endtask

  // Issue one transaction; offset is the hand-computed number of cycles from now until ack.
  task automatic apply_stimulus(input int dut, input bit port, input bit we,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] exp_data, input int offset,
                                input bit keep, input string name);
    exp_t e;
    int   k;
    bit   got;
    k = ((dut == 3) ? 2 : 0) + int'(port);
    drive(dut, port, 1'b1, we, addr, wdata);
    e.is_read = !we;
    e.data    = exp_data;
    e.cycle   = cycle + offset;
    e.name    = name;
    sb[k].push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = get_ack(dut, port);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: ack=0 required=1 within 40 cycles", name);
    end
    if (!keep || !got) drive(dut, port, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic check_output(input int k, input logic [15:0] rd, input logic gid);
    exp_t e;
    checks++;
    if (sb[k].size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_ack ch%0d at cycle %0d: ack=1 required=0", k, cycle);
      return;
    end
    e = sb[k].pop_front();
    if (cycle != e.cycle) begin
      errors++;
      $display("[TB] FAIL %s_ack_cycle: actual=%0d required=%0d", e.name, cycle, e.cycle);
    end
    checks++;
    if (gid !== k[0]) begin
      errors++;
      $display("[TB] FAIL %s_grant_id: actual=%0d required=%0d", e.name, gid, k[0]);
    end
    if (e.is_read) begin
      checks++;
      if (rd !== e.data) begin
        errors++;
        $display("[TB] FAIL %s_rdata: actual=%h required=%h", e.name, rd, e.data);
      end
    end
  endtask

  always @(negedge clock) begin
    mon_ack   = {bus3.b_ack, bus3.a_ack, bus1.b_ack, bus1.a_ack};
    mon_gid   = {bus3.grant_id, bus3.grant_id, bus1.grant_id, bus1.grant_id};
    mon_rd[0] = bus1.a_rdata;
    mon_rd[1] = bus1.b_rdata;
    mon_rd[2] = bus3.a_rdata;
    mon_rd[3] = bus3.b_rdata;
    for (int k = 0; k < 4; k++) begin
      if (mon_ack[k]) check_output(k, mon_rd[k], mon_gid[k]);
    end
    if (|mon_ack[1:0]) begin
      checks++;
      if (&mon_ack[1:0]) begin
        errors++;
        $display("[TB] FAIL ack_overlap_lat1: a_ack=1 b_ack=1 required at most one");
      end
    end
    if (|mon_ack[3:2]) begin
      checks++;
      if (&mon_ack[3:2]) begin
        errors++;
        $display("[TB] FAIL ack_overlap_lat3: a_ack=1 b_ack=1 required at most one");
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    rst1 = 1'b0;
    rst3 = 1'b0;
    for (int d = 1; d <= 3; d += 2) begin
      drive(d, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(d, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end

    // Reset held: inputs toggle, outputs stay zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      for (int d = 1; d <= 3; d += 2) begin
        drive(d, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        drive(d, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      end
      @(posedge clock);
      #1;
      expect_zero(1, "reset_hold_lat1");
      expect_zero(3, "reset_hold_lat3");
    end
    @(negedge clock);
    for (int d = 1; d <= 3; d += 2) begin
      drive(d, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(d, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    @(negedge clock);
    rst1 = 1'b1;
    rst3 = 1'b1;
    idle(2);
    expect_zero(1, "reset_release_lat1");
    expect_zero(3, "reset_release_lat3");

    // Latency 1: A write, strobe exactly one cycle, then read back on A and on B.
    fork
      apply_stimulus(1, 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 2, 1'b0, "a_write");
      begin
        @(negedge clock);
        check_val("write_strobe_on", 16'(bus1.ram_rw), 16'h0001);
        check_val("write_address", bus1.ram_address, 16'h0010);
        check_val("write_data", bus1.ram_data_out, 16'h1234);
        @(negedge clock);
        check_val("write_strobe_off", 16'(bus1.ram_rw), 16'h0000);
      end
    join
    idle(2);
    apply_stimulus(1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 2, 1'b0, "a_read_lat1");
    idle(2);
    apply_stimulus(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 2, 1'b0, "b_read_lat1");

    // Latency 3: B read of the top address leaves A's rdata alone; 0xFFFF round trip.
    idle(2);
    apply_stimulus(3, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A20, 4, 1'b0, "a_read_lat3");
    idle(2);
    apply_stimulus(3, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 4, 1'b0, "b_read_ffff");
    check_val("a_rdata_held", bus3.a_rdata, 16'h5A20);
    idle(2);
    apply_stimulus(3, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 2, 1'b0, "b_write_ffff");
    idle(2);
    apply_stimulus(3, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 4, 1'b0, "a_read_ffff");
    check_val("b_rdata_held", bus3.b_rdata, 16'hBEEF);

    // Latency 1: both ports request continuously, 4 reads each; A wins the first tie.
    idle(2);
    s = cycle;
    fork
      for (int i = 0; i < 4; i++)
        apply_stimulus(1, 1'b0, 1'b0, 16'(16'h0100 + i), 16'h0000, seed_value(16'(16'h0100 + i)),
                       (i == 0) ? 2 : 6, (i < 3), "alt_a");
      for (int i = 0; i < 4; i++)
        apply_stimulus(1, 1'b1, 1'b0, 16'(16'h0200 + i), 16'h0000, seed_value(16'(16'h0200 + i)),
                       (i == 0) ? 5 : 6, (i < 3), "alt_b");
      for (int j = 1; j <= 24; j++) begin
        @(negedge clock);
        check_val("alt_busy", 16'(bus1.busy), 16'(((cycle - s) % 3) != 0));
      end
    join

    // Latency 3: B raises its request while A is in WAIT; granted after A's DONE.
    idle(2);
    fork
      apply_stimulus(3, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A40, 4, 1'b0, "a_read_wait");
      begin
        idle(2);
        apply_stimulus(3, 1'b1, 1'b0, 16'h0041, 16'h0000, 16'h5A41, 7, 1'b0, "b_during_wait");
      end
    join

    // Latency 3: reset pulse mid-read abandons the access without an ack.
    idle(3);
    drive(3, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(2);
    #2;
    rst3 = 1'b0;
    #1;
    expect_zero(3, "reset_mid_access");
    drive(3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(3);
    expect_zero(3, "reset_mid_access_hold");
    rst3 = 1'b1;
    idle(6);
    expect_zero(3, "after_reset_idle");
    apply_stimulus(3, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'h5A31, 4, 1'b0, "a_read_after_reset");

    idle(4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("[TB] FAIL missing_ack ch%0d: pending=%0d required=0", k, sb[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
